// File: rtl/fsm_mestre.sv
// Bottling-line master: start command, cork stock with alarm/auto-resume, approved-bottle tally.
// Optional batch-target state META is built only when FSM_MESTRE_META_EN is defined.
module fsm_mestre #(
  parameter int ROLHAS_INICIAL = 20,
  parameter int ROLHAS_MAX     = 99,
  parameter int REPOSICAO      = 15
`ifdef FSM_MESTRE_META_EN
  ,
  parameter int META_DUZIAS    = 5
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       repor,
  input  logic       decrementar_rolha,
  input  logic       garrafa_aprovada,
  output logic       cmd_iniciar,
  output logic       alarme_rolha,
  output logic [6:0] rolhas,
  output logic [3:0] unidades,
  output logic [3:0] duzias,
  output logic       lote_completo,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    PARADO  = 2'b00,
    RODANDO = 2'b01,
    ALARME  = 2'b10,
    META    = 2'b11
  } estado_t;

  localparam logic [7:0] REPO8   = 8'(REPOSICAO);
  localparam logic [7:0] MAX8    = 8'(ROLHAS_MAX);
  localparam logic [6:0] INICIAL = 7'(ROLHAS_INICIAL);

  estado_t    state, state_next;
  logic       iniciar_prev, repor_prev, dec_prev, apr_prev;
  logic       ev_iniciar, ev_repor, ev_dec, ev_apr;
  logic       em_meta;
  logic [7:0] soma;
  logic [6:0] rolhas_next;
  logic [3:0] unidades_next, duzias_next;

  assign em_meta    = (state == META);

  // Only restock survives once the batch is complete.
  assign ev_iniciar = iniciar & ~iniciar_prev & ~em_meta;
  assign ev_repor   = repor & ~repor_prev;
  assign ev_dec     = decrementar_rolha & ~dec_prev & ~em_meta;
  assign ev_apr     = garrafa_aprovada & ~apr_prev & ~em_meta;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    soma = {1'b0, rolhas};
    if (ev_repor) soma = soma + REPO8;
    if (ev_dec && rolhas != 7'd0) soma = soma - 8'd1;
    if (soma > MAX8) soma = MAX8;
    rolhas_next = soma[6:0];
  end

  always_comb begin
    unidades_next = unidades;
    duzias_next   = duzias;
    if (ev_apr) begin
      if (unidades == 4'd11) begin
        unidades_next = 4'd0;
`ifdef FSM_MESTRE_META_EN
        if (duzias < 4'(META_DUZIAS)) duzias_next = duzias + 4'd1;
`else
        duzias_next = (duzias == 4'd9) ? 4'd0 : duzias + 4'd1;
`endif
      end else begin
        unidades_next = unidades + 4'd1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    cmd_iniciar = 1'b0;
    case (state)
      PARADO:  if (ev_iniciar && rolhas != 7'd0) state_next = RODANDO;
      RODANDO: begin
        cmd_iniciar = 1'b1;
        if (rolhas == 7'd0) state_next = ALARME;
      end
      ALARME:  if (rolhas != 7'd0) state_next = RODANDO;
      default: state_next = state;
    endcase
`ifdef FSM_MESTRE_META_EN
    // Target check overrides the alarm transition when both hold.
    if (!em_meta && duzias == 4'(META_DUZIAS)) state_next = META;
`endif
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block and is sampled only at the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= PARADO;
      iniciar_prev <= 1'b0;
      repor_prev   <= 1'b0;
      dec_prev     <= 1'b0;
      apr_prev     <= 1'b0;
      rolhas       <= INICIAL;
      unidades     <= 4'd0;
      duzias       <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state        <= state_next;
      iniciar_prev <= iniciar;
      repor_prev   <= repor;
      dec_prev     <= decrementar_rolha;
      apr_prev     <= garrafa_aprovada;
      rolhas       <= rolhas_next;
      unidades     <= unidades_next;
      duzias       <= duzias_next;
    end
  end

  assign alarme_rolha = (rolhas == 7'd0);
  assign estado       = state;
`ifdef FSM_MESTRE_META_EN
  assign lote_completo = em_meta;
`else
  assign lote_completo = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_mestre.sv
// Directed self-checking bench for fsm_mestre: reset, cork stock, alarm/resume, saturation, dozens.
module tb_fsm_mestre;

  logic       clk = 1'b0;
  logic       reset, iniciar, repor, decrementar_rolha, garrafa_aprovada;
  logic       cmd_iniciar, alarme_rolha, lote_completo;
  logic [6:0] rolhas;
  logic [3:0] unidades, duzias;
  logic [1:0] estado;
  int         n_cmp = 0;
  int         n_err = 0;

  always #10 clk = ~clk;

`ifdef FSM_MESTRE_META_EN
  fsm_mestre #(.META_DUZIAS(2)) dut (
`else
  fsm_mestre dut (
`endif
    .clk(clk), .reset(reset), .iniciar(iniciar), .repor(repor),
    .decrementar_rolha(decrementar_rolha), .garrafa_aprovada(garrafa_aprovada),
    .cmd_iniciar(cmd_iniciar), .alarme_rolha(alarme_rolha), .rolhas(rolhas),
    .unidades(unidades), .duzias(duzias), .lote_completo(lote_completo), .estado(estado)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 iniciar, 1 repor, 2 decrementar, 3 aprovada
  task automatic pulse(input int sel, input int n);
    repeat (n) begin
      case (sel)
        0: iniciar = 1'b1;
        1: repor = 1'b1;
        2: decrementar_rolha = 1'b1;
        default: garrafa_aprovada = 1'b1;
      endcase
      tick();
      iniciar = 1'b0; repor = 1'b0; decrementar_rolha = 1'b0; garrafa_aprovada = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    iniciar = 0; repor = 0; decrementar_rolha = 0; garrafa_aprovada = 0;
    do_reset();
    n_cmp++; if (rolhas !== 7'd20) begin n_err++; $display("FAIL reset_rolhas got %0d exp 20", rolhas); end
    n_cmp++; if (unidades !== 4'd0 || duzias !== 4'd0) begin n_err++; $display("FAIL reset_counts got %0d/%0d exp 0/0", unidades, duzias); end
    n_cmp++; if (cmd_iniciar !== 1'b0 || alarme_rolha !== 1'b0 || lote_completo !== 1'b0) begin n_err++; $display("FAIL reset_flags got cmd=%b alm=%b lote=%b exp 0 0 0", cmd_iniciar, alarme_rolha, lote_completo); end
    n_cmp++; if (estado !== 2'b00) begin n_err++; $display("FAIL reset_estado got %b exp 00", estado); end
  endtask

  task automatic test_start_decrement();
    iniciar = 1'b1;
    tick();
    n_cmp++; if (cmd_iniciar !== 1'b1 || estado !== 2'b01) begin n_err++; $display("FAIL start got cmd=%b estado=%b exp 1 01", cmd_iniciar, estado); end
    iniciar = 1'b0;
    decrementar_rolha = 1'b1;
    repeat (100) tick();
    n_cmp++; if (rolhas !== 7'd19) begin n_err++; $display("FAIL held_decrement got %0d exp 19", rolhas); end
    decrementar_rolha = 1'b0;
    tick();
  endtask

  task automatic test_alarm_resume();
    pulse(2, 19);
    n_cmp++; if (rolhas !== 7'd0 || alarme_rolha !== 1'b1) begin n_err++; $display("FAIL alarm_count got %0d alm=%b exp 0 1", rolhas, alarme_rolha); end
    n_cmp++; if (estado !== 2'b10 || cmd_iniciar !== 1'b0) begin n_err++; $display("FAIL alarm_state got estado=%b cmd=%b exp 10 0", estado, cmd_iniciar); end
    pulse(2, 1);
    n_cmp++; if (rolhas !== 7'd0) begin n_err++; $display("FAIL decrement_at_zero got %0d exp 0", rolhas); end
    repor = 1'b1;
    tick();
    repor = 1'b0;
    n_cmp++; if (rolhas !== 7'd15 || alarme_rolha !== 1'b0 || estado !== 2'b10) begin n_err++; $display("FAIL restock_edge got %0d alm=%b estado=%b exp 15 0 10", rolhas, alarme_rolha, estado); end
    tick();
    n_cmp++; if (estado !== 2'b01 || cmd_iniciar !== 1'b1) begin n_err++; $display("FAIL resume got estado=%b cmd=%b exp 01 1", estado, cmd_iniciar); end
  endtask

  task automatic test_simultaneous();
    pulse(1, 5);
    n_cmp++; if (rolhas !== 7'd90) begin n_err++; $display("FAIL restock_to_90 got %0d exp 90", rolhas); end
    repor = 1'b1; decrementar_rolha = 1'b1;
    tick();
    repor = 1'b0; decrementar_rolha = 1'b0;
    tick();
    n_cmp++; if (rolhas !== 7'd99) begin n_err++; $display("FAIL both_at_90 got %0d exp 99", rolhas); end
    pulse(1, 1);
    n_cmp++; if (rolhas !== 7'd99) begin n_err++; $display("FAIL restock_at_max got %0d exp 99", rolhas); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (rolhas !== 7'd20 || estado !== 2'b00 || cmd_iniciar !== 1'b0) begin n_err++; $display("FAIL midop_reset got %0d estado=%b cmd=%b exp 20 00 0", rolhas, estado, cmd_iniciar); end
    pulse(2, 20);
    n_cmp++; if (rolhas !== 7'd0 || alarme_rolha !== 1'b1 || estado !== 2'b00) begin n_err++; $display("FAIL empty_parado got %0d alm=%b estado=%b exp 0 1 00", rolhas, alarme_rolha, estado); end
    pulse(0, 1);
    n_cmp++; if (estado !== 2'b00 || cmd_iniciar !== 1'b0) begin n_err++; $display("FAIL start_empty got estado=%b cmd=%b exp 00 0", estado, cmd_iniciar); end
    repor = 1'b1; decrementar_rolha = 1'b1;
    tick();
    repor = 1'b0; decrementar_rolha = 1'b0;
    tick();
    n_cmp++; if (rolhas !== 7'd15) begin n_err++; $display("FAIL both_at_0 got %0d exp 15", rolhas); end
  endtask

  task automatic test_dozen_rollover();
    pulse(3, 11);
    n_cmp++; if (unidades !== 4'd11 || duzias !== 4'd0) begin n_err++; $display("FAIL eleven got %0d/%0d exp 11/0", unidades, duzias); end
    pulse(3, 1);
    n_cmp++; if (unidades !== 4'd0 || duzias !== 4'd1) begin n_err++; $display("FAIL first_dozen got %0d/%0d exp 0/1", unidades, duzias); end
`ifndef FSM_MESTRE_META_EN
    pulse(3, 107);
    n_cmp++; if (unidades !== 4'd11 || duzias !== 4'd9) begin n_err++; $display("FAIL at_119 got %0d/%0d exp 11/9", unidades, duzias); end
    pulse(3, 1);
    n_cmp++; if (unidades !== 4'd0 || duzias !== 4'd0 || lote_completo !== 1'b0) begin n_err++; $display("FAIL wrap_120 got %0d/%0d lote=%b exp 0/0 0", unidades, duzias, lote_completo); end
`endif
  endtask

  task automatic test_back_to_back();
    garrafa_aprovada = 1'b1;
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++; if (unidades !== 4'd0) begin n_err++; $display("FAIL no_count_in_reset got %0d exp 0", unidades); end
    reset = 1'b1;
    tick();
    n_cmp++; if (unidades !== 4'd1) begin n_err++; $display("FAIL high_at_release got %0d exp 1", unidades); end
    repeat (50) tick();
    n_cmp++; if (unidades !== 4'd1) begin n_err++; $display("FAIL held_approve got %0d exp 1", unidades); end
    garrafa_aprovada = 1'b0;
    tick();
    garrafa_aprovada = 1'b1;
    tick();
    garrafa_aprovada = 1'b0;
    tick();
    n_cmp++; if (unidades !== 4'd2) begin n_err++; $display("FAIL one_low_gap got %0d exp 2", unidades); end
  endtask

`ifdef FSM_MESTRE_META_EN
  task automatic test_meta();
    do_reset();
    pulse(0, 1);
    pulse(3, 24);
    n_cmp++; if (lote_completo !== 1'b1 || estado !== 2'b11 || cmd_iniciar !== 1'b0) begin n_err++; $display("FAIL meta got lote=%b estado=%b cmd=%b exp 1 11 0", lote_completo, estado, cmd_iniciar); end
    pulse(0, 1);
    pulse(2, 1);
    pulse(3, 1);
    n_cmp++; if (estado !== 2'b11 || rolhas !== 7'd20 || unidades !== 4'd0 || duzias !== 4'd2) begin n_err++; $display("FAIL meta_ignore got estado=%b rolhas=%0d u=%0d d=%0d exp 11 20 0 2", estado, rolhas, unidades, duzias); end
    pulse(1, 1);
    n_cmp++; if (rolhas !== 7'd35) begin n_err++; $display("FAIL meta_restock got %0d exp 35", rolhas); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    test_reset();
    test_start_decrement();
    test_alarm_resume();
    test_simultaneous();
    test_dozen_rollover();
    test_back_to_back();
`ifdef FSM_MESTRE_META_EN
    test_meta();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
